spi_sram_prefetch_bridge: RTL and testbench

//  CPU-side front end for spi_sram_master. Turns single-byte CPU bus requests into master commands.

---
 rtl/spi_mem_pkg.sv | 22 ++
 rtl/spi_sram_prefetch_bridge_if.sv | 32 +++
 rtl/spi_sram_prefetch_bridge.sv | 159 +++++++++++++++
 tb/tb_spi_sram_prefetch_bridge.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI SRAM CPU-side bridge: state encoding,
// address defaults and the address helper used to form master addresses.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CMD,
        ST_RD_CMD,
        ST_RD_WAIT,
        ST_PF_WAIT
    } bridge_state_e;

    localparam logic [23:0] ADDR_BASE_DEFAULT = 24'h000000;
    localparam logic [15:0] NO_PF_ADDR        = 16'hFFFF;

    // Carry out of bit 23 is intentionally dropped.
    function automatic logic [23:0] form_mem_addr(input logic [23:0] base,
                                                  input logic [15:0] cpu_addr);
        return base + {8'h00, cpu_addr};
    endfunction

endpackage

// File: rtl/spi_sram_prefetch_bridge_if.sv
// Bus bundles for the bridge: CPU request/complete bus and the command bus
// towards spi_sram_master. Signal names match the flat-port original.
interface cpu_bus_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_done;
    logic [7:0]  cpu_rdata;

    modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata,
                    input  cpu_done, cpu_rdata);
    modport slave  (input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
                    output cpu_done, cpu_rdata);
endinterface

interface mem_bus_if;
    logic        mem_en;
    logic        mem_wr;
    logic        mem_rburst;
    logic        mem_wburst;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rdy;
    logic [7:0]  mem_rdata0;
    logic        mem_rdata_load;

    modport master (output mem_en, mem_wr, mem_rburst, mem_wburst, mem_addr, mem_wdata,
                    input  mem_rdy, mem_rdata0, mem_rdata_load);
    modport slave  (input  mem_en, mem_wr, mem_rburst, mem_wburst, mem_addr, mem_wdata,
                    output mem_rdy, mem_rdata0, mem_rdata_load);
endinterface

// File: rtl/spi_sram_prefetch_bridge.sv
// CPU front end for spi_sram_master: single-byte requests become master commands,
// and reads keep the SPI burst open to prefetch or stream the next sequential byte.
module spi_sram_prefetch_bridge
    import spi_mem_pkg::*;
#(
    parameter logic [23:0] ADDR_BASE = ADDR_BASE_DEFAULT,
    parameter bit          PREFETCH  = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    cpu_bus_if.slave  cpu,
    mem_bus_if.master mem
);

    bridge_state_e state_q, state_d;
    logic          cpu_done_q, cpu_done_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic          pf_valid_q, pf_valid_d;
    logic [15:0]   pf_addr_q, pf_addr_d;
    logic [7:0]    pf_data_q, pf_data_d;

    logic new_req;
    logic pf_ok;
    logic pf_hit;
    logic stream_hit;
    logic demand_last;
    logic write_pending;

    // The request is still held during the cpu_done cycle; it must not be taken twice.
    assign new_req       = cpu.cpu_req && !cpu_done_q;
    assign pf_ok         = PREFETCH && (cpu.cpu_addr != NO_PF_ADDR);
    assign pf_hit        = new_req && !cpu.cpu_we && pf_valid_q && (cpu.cpu_addr == pf_addr_q);
    assign stream_hit    = new_req && !cpu.cpu_we && (cpu.cpu_addr == pf_addr_q)
                           && (pf_addr_q != NO_PF_ADDR);
    assign demand_last   = new_req && !cpu.cpu_we && (cpu.cpu_addr == pf_addr_q)
                           && (pf_addr_q == NO_PF_ADDR);
    assign write_pending = new_req && cpu.cpu_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cpu_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            pf_valid_q  <= 1'b0;
            pf_addr_q   <= '0;
            pf_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cpu_done_q  <= cpu_done_d;
            cpu_rdata_q <= cpu_rdata_d;
            pf_valid_q  <= pf_valid_d;
            pf_addr_q   <= pf_addr_d;
            pf_data_q   <= pf_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cpu_done_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        pf_valid_d  = pf_valid_q;
        pf_addr_d   = pf_addr_q;
        pf_data_d   = pf_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pf_hit) begin
                    cpu_rdata_d = pf_data_q;
                    cpu_done_d  = 1'b1;
                    pf_valid_d  = 1'b0;
                end else if (write_pending) begin
                    pf_valid_d = 1'b0;
                    state_d    = ST_WR_CMD;
                end else if (new_req) begin
                    pf_valid_d = 1'b0;
                    state_d    = ST_RD_CMD;
                end
            end
            ST_WR_CMD: begin
                if (mem.mem_rdy) begin
                    cpu_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_RD_CMD: begin
                if (mem.mem_rdy) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem.mem_rdata_load) begin
                    cpu_rdata_d = mem.mem_rdata0;
                    cpu_done_d  = 1'b1;
                    pf_addr_d   = (cpu.cpu_addr == NO_PF_ADDR) ? NO_PF_ADDR
                                                               : cpu.cpu_addr + 16'd1;
                    state_d     = pf_ok ? ST_PF_WAIT : ST_IDLE;
                end
            end
            ST_PF_WAIT: begin
                if (mem.mem_rdata_load) begin
                    if (stream_hit) begin
                        cpu_rdata_d = mem.mem_rdata0;
                        cpu_done_d  = 1'b1;
                        pf_addr_d   = pf_addr_q + 16'd1;
                    end else if (demand_last) begin
                        cpu_rdata_d = mem.mem_rdata0;
                        cpu_done_d  = 1'b1;
                        pf_valid_d  = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        // A write seen with the closing strobe makes the byte stale at once.
                        pf_data_d  = mem.mem_rdata0;
                        pf_valid_d = !write_pending;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem.mem_en     = 1'b0;
        mem.mem_wr     = 1'b0;
        mem.mem_rburst = 1'b0;

        unique case (state_q)
            ST_WR_CMD: begin
                mem.mem_en = 1'b1;
                mem.mem_wr = 1'b1;
            end
            ST_RD_CMD: begin
                mem.mem_en     = 1'b1;
                mem.mem_rburst = pf_ok;
            end
            // Burst continuation must be visible in the strobe cycle itself.
            ST_RD_WAIT: begin
                if (mem.mem_rdata_load && pf_ok) begin
                    mem.mem_en     = 1'b1;
                    mem.mem_rburst = 1'b1;
                end
            end
            ST_PF_WAIT: begin
                if (mem.mem_rdata_load && stream_hit) begin
                    mem.mem_en     = 1'b1;
                    mem.mem_rburst = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign mem.mem_wburst = 1'b0;
    assign mem.mem_addr   = form_mem_addr(ADDR_BASE, cpu.cpu_addr);
    assign mem.mem_wdata  = cpu.cpu_wdata;
    assign cpu.cpu_done   = cpu_done_q;
    assign cpu.cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_spi_sram_prefetch_bridge.sv
// Bench for spi_sram_prefetch_bridge: two DUTs (PREFETCH=1 and PREFETCH=0), each
// with a behavioural master+SRAM model (32-clock command, 8 clocks per byte, 40-clock write).
module tb_spi_sram_prefetch_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_a   [2];
    logic        we_a    [2];
    logic [15:0] addr_a  [2];
    logic [7:0]  wdata_a [2];
    logic [1:0]  done_v;
    logic [7:0]  rdata_a [2];
    logic [1:0]  en_v, wr_v, rb_v, wb_v;

    logic        preload_en = 1'b0;
    logic [15:0] preload_addr = '0;
    logic [7:0]  preload_data = '0;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] shadow[int];

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] expect_byte(input logic [15:0] a);
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return pat(a);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen
        cpu_bus_if cb();
        mem_bus_if mb();

        spi_sram_prefetch_bridge #(.ADDR_BASE(24'h000000), .PREFETCH(g == 0)) dut (
            .clk (clk),
            .rst (rst),
            .cpu (cb),
            .mem (mb)
        );

        assign cb.cpu_req   = req_a[g];
        assign cb.cpu_we    = we_a[g];
        assign cb.cpu_addr  = addr_a[g];
        assign cb.cpu_wdata = wdata_a[g];
        assign done_v[g]    = cb.cpu_done;
        assign rdata_a[g]   = cb.cpu_rdata;
        assign en_v[g]      = mb.mem_en;
        assign wr_v[g]      = mb.mem_wr;
        assign rb_v[g]      = mb.mem_rburst;
        assign wb_v[g]      = mb.mem_wburst;

        logic [7:0]  mem     [0:65535];
        bit          written [0:65535];
        int          mst = 0;
        int          mcnt = 0;
        logic [15:0] maddr = '0;
        logic [7:0]  mwdata = '0;
        logic        m_load = 1'b0;
        logic [7:0]  m_rdata = '0;
        int          cmd_count = 0;
        int          cs_rise = 0;
        logic        last_rburst = 1'b0;
        logic        last_wr = 1'b0;
        logic        cs_n;
        logic        cs_prev = 1'b1;
        int          done_cnt = 0;
        int          consec = 0;
        logic        done_prev = 1'b0;

        assign cs_n              = (mst == 0);
        assign mb.mem_rdy        = (mst == 0);
        assign mb.mem_rdata_load = m_load;
        assign mb.mem_rdata0     = m_rdata;

        always @(posedge clk) begin
            m_load  <= 1'b0;
            cs_prev <= cs_n;
            if (cs_n && !cs_prev) cs_rise <= cs_rise + 1;
            if (preload_en) begin
                mem[preload_addr]     <= preload_data;
                written[preload_addr] <= 1'b1;
            end
            if (rst) begin
                mst <= 0;
            end else begin
                case (mst)
                    0: if (mb.mem_en) begin
                        cmd_count   <= cmd_count + 1;
                        maddr       <= mb.mem_addr[15:0];
                        last_wr     <= mb.mem_wr;
                        last_rburst <= mb.mem_rburst;
                        if (mb.mem_wr) begin
                            mwdata <= mb.mem_wdata;
                            mcnt   <= 39;
                            mst    <= 1;
                        end else begin
                            mcnt <= 31;
                            mst  <= 2;
                        end
                    end
                    1: if (mcnt == 0) begin
                        mem[maddr]     <= mwdata;
                        written[maddr] <= 1'b1;
                        mst            <= 0;
                    end else mcnt <= mcnt - 1;
                    2: if (mcnt == 0) begin
                        m_load  <= 1'b1;
                        m_rdata <= written[maddr] ? mem[maddr] : pat(maddr);
                        mst     <= 3;
                    end else mcnt <= mcnt - 1;
                    3: if (mb.mem_en && mb.mem_rburst) begin
                        maddr <= maddr + 16'd1;
                        mcnt  <= 6;
                        mst   <= 2;
                    end else mst <= 0;
                    default: mst <= 0;
                endcase
            end
        end

        always @(negedge clk) begin
            done_prev <= cb.cpu_done;
            if (cb.cpu_done) done_cnt <= done_cnt + 1;
            if (cb.cpu_done && done_prev) consec <= consec + 1;
        end
    end

    function automatic int get_cmd(input int sel);
        return (sel == 0) ? gen[0].cmd_count : gen[1].cmd_count;
    endfunction
    function automatic int get_rise(input int sel);
        return (sel == 0) ? gen[0].cs_rise : gen[1].cs_rise;
    endfunction
    function automatic int get_done(input int sel);
        return (sel == 0) ? gen[0].done_cnt : gen[1].done_cnt;
    endfunction
    function automatic logic get_rburst(input int sel);
        return (sel == 0) ? gen[0].last_rburst : gen[1].last_rburst;
    endfunction

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        preload_en   = 1'b1;
        preload_addr = a;
        preload_data = d;
        @(negedge clk);
        preload_en   = 1'b0;
        shadow[int'(a)] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_a[i] = 1'b0; we_a[i] = 1'b0; addr_a[i] = '0; wdata_a[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Drives one request, waits (bounded) for cpu_done, pops the scoreboard on reads.
    task automatic cpu_access(input int sel, input logic we, input logic [15:0] a,
                              input logic [7:0] wd, input string nm, output int cyc);
        logic [7:0] e;
        int n;
        if (we) shadow[int'(a)] = wd;
        else exp_q.push_back(expect_byte(a));
        req_a[sel] = 1'b1; we_a[sel] = we; addr_a[sel] = a; wdata_a[sel] = wd;
        n = 0;
        cyc = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_v[sel] && n < 2000);
        checks++;
        if (!done_v[sel]) begin
            errors++;
            $display("FAIL %s: cpu_done not seen, waited %0d cycles, required within 2000", nm, n);
            if (!we) void'(exp_q.pop_front());
        end else begin
            cyc = n;
            if (!we) begin
                e = exp_q.pop_front();
                if (rdata_a[sel] !== e) begin
                    errors++;
                    $display("FAIL %s: cpu_rdata=%h expected %h", nm, rdata_a[sel], e);
                end
            end
        end
        req_a[sel] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            checks++; if (done_v[i] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b expected 0", i, done_v[i]); end
            checks++; if (rdata_a[i] !== 8'h00) begin errors++; $display("FAIL reset_rdata[%0d]: got %h expected 00", i, rdata_a[i]); end
            checks++; if (en_v[i] !== 1'b0) begin errors++; $display("FAIL reset_mem_en[%0d]: got %b expected 0", i, en_v[i]); end
            checks++; if (wr_v[i] !== 1'b0) begin errors++; $display("FAIL reset_mem_wr[%0d]: got %b expected 0", i, wr_v[i]); end
            checks++; if (rb_v[i] !== 1'b0) begin errors++; $display("FAIL reset_rburst[%0d]: got %b expected 0", i, rb_v[i]); end
            checks++; if (wb_v[i] !== 1'b0) begin errors++; $display("FAIL reset_wburst[%0d]: got %b expected 0", i, wb_v[i]); end
        end
    endtask

    task automatic test_write();
        int c0, r0, d0, cyc;
        c0 = get_cmd(0); r0 = get_rise(0); d0 = get_done(0);
        cpu_access(0, 1'b1, 16'h0200, 8'hA5, "write_a5", cyc);
        checks++; if (cyc != 2) begin errors++; $display("FAIL write_latency: got %0d expected 2", cyc); end
        repeat (30) @(negedge clk);
        checks++; if (get_rise(0) - r0 != 0) begin errors++; $display("FAIL write_cs_early: rises %0d expected 0", get_rise(0) - r0); end
        repeat (20) @(negedge clk);
        checks++; if (get_cmd(0) - c0 != 1) begin errors++; $display("FAIL write_cmds: got %0d expected 1", get_cmd(0) - c0); end
        checks++; if (gen[0].last_wr !== 1'b1) begin errors++; $display("FAIL write_is_wr: got %b expected 1", gen[0].last_wr); end
        checks++; if (get_rise(0) - r0 != 1) begin errors++; $display("FAIL write_cs_rise: got %0d expected 1", get_rise(0) - r0); end
        checks++; if (get_done(0) - d0 != 1) begin errors++; $display("FAIL write_done_once: got %0d expected 1", get_done(0) - d0); end
        c0 = get_cmd(0);
        cpu_access(0, 1'b0, 16'h0200, 8'h00, "write_readback", cyc);
        checks++; if (get_cmd(0) - c0 != 1) begin errors++; $display("FAIL write_pf_invalid: cmds %0d expected 1", get_cmd(0) - c0); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_prefetch();
        int c0, cyc;
        preload(16'h0300, 8'h11);
        preload(16'h0301, 8'h22);
        c0 = get_cmd(0);
        cpu_access(0, 1'b0, 16'h0300, 8'h00, "pf_first_read", cyc);
        checks++; if (get_rburst(0) !== 1'b1) begin errors++; $display("FAIL pf_cmd_rburst: got %b expected 1", get_rburst(0)); end
        repeat (20) @(negedge clk);
        cpu_access(0, 1'b0, 16'h0301, 8'h00, "pf_hit_read", cyc);
        checks++; if (cyc != 1) begin errors++; $display("FAIL pf_hit_latency: got %0d expected 1", cyc); end
        checks++; if (get_cmd(0) - c0 != 1) begin errors++; $display("FAIL pf_hit_cmds: got %0d expected 1", get_cmd(0) - c0); end
        c0 = get_cmd(0);
        cpu_access(0, 1'b0, 16'h0301, 8'h00, "pf_consumed_read", cyc);
        checks++; if (get_cmd(0) - c0 != 1) begin errors++; $display("FAIL pf_consumed_cmds: got %0d expected 1", get_cmd(0) - c0); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int c0, r0, cyc;
        c0 = get_cmd(0); r0 = get_rise(0);
        for (int i = 0; i < 8; i++) begin
            cpu_access(0, 1'b0, 16'h0400 + 16'(i), 8'h00, "b2b_read", cyc);
            if (i > 0) begin
                checks++; if (cyc > 8) begin errors++; $display("FAIL b2b_stream_latency[%0d]: got %0d expected <=8", i, cyc); end
            end
        end
        checks++; if (get_cmd(0) - c0 != 1) begin errors++; $display("FAIL b2b_cmds: got %0d expected 1", get_cmd(0) - c0); end
        checks++; if (get_rise(0) - r0 != 0) begin errors++; $display("FAIL b2b_cs_low: rises %0d expected 0", get_rise(0) - r0); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_write_during_pf();
        int c0, cyc;
        c0 = get_cmd(0);
        cpu_access(0, 1'b0, 16'h0500, 8'h00, "wpf_read", cyc);
        cpu_access(0, 1'b1, 16'h0501, 8'h77, "wpf_write", cyc);
        checks++; if (cyc < 8) begin errors++; $display("FAIL wpf_write_held: latency %0d expected >=8", cyc); end
        cpu_access(0, 1'b0, 16'h0501, 8'h00, "wpf_readback", cyc);
        checks++; if (get_cmd(0) - c0 != 3) begin errors++; $display("FAIL wpf_cmds: got %0d expected 3", get_cmd(0) - c0); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_wrap();
        int c0, cyc;
        preload(16'hFFFF, 8'hC3);
        c0 = get_cmd(0);
        cpu_access(0, 1'b0, 16'hFFFE, 8'h00, "wrap_fffe", cyc);
        checks++; if (get_rburst(0) !== 1'b1) begin errors++; $display("FAIL wrap_fffe_rburst: got %b expected 1", get_rburst(0)); end
        cpu_access(0, 1'b0, 16'hFFFF, 8'h00, "wrap_ffff_demand", cyc);
        checks++; if (get_cmd(0) - c0 != 1) begin errors++; $display("FAIL wrap_demand_cmds: got %0d expected 1", get_cmd(0) - c0); end
        repeat (20) @(negedge clk);
        c0 = get_cmd(0);
        cpu_access(0, 1'b0, 16'hFFFF, 8'h00, "wrap_ffff_again", cyc);
        checks++; if (get_cmd(0) - c0 != 1) begin errors++; $display("FAIL wrap_ffff_cmds: got %0d expected 1", get_cmd(0) - c0); end
        checks++; if (get_rburst(0) !== 1'b0) begin errors++; $display("FAIL wrap_ffff_rburst: got %b expected 0", get_rburst(0)); end
        repeat (20) @(negedge clk);
        c0 = get_cmd(0);
        cpu_access(0, 1'b0, 16'h0000, 8'h00, "wrap_zero", cyc);
        checks++; if (get_cmd(0) - c0 != 1) begin errors++; $display("FAIL wrap_zero_cmds: got %0d expected 1", get_cmd(0) - c0); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_no_prefetch();
        int c0, cyc;
        c0 = get_cmd(1);
        for (int i = 0; i < 3; i++) begin
            cpu_access(1, 1'b0, 16'h0300 + 16'(i), 8'h00, "nopf_read", cyc);
            checks++; if (get_rburst(1) !== 1'b0) begin errors++; $display("FAIL nopf_rburst[%0d]: got %b expected 0", i, get_rburst(1)); end
        end
        checks++; if (get_cmd(1) - c0 != 3) begin errors++; $display("FAIL nopf_cmds: got %0d expected 3", get_cmd(1) - c0); end
    endtask

    task automatic test_reset_mid();
        int c0, cyc, n;
        preload(16'h0600, 8'h96);
        c0 = get_cmd(0);
        req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0] = 16'h0600;
        n = 0;
        while (get_cmd(0) == c0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (get_cmd(0) == c0) begin errors++; $display("FAIL rstmid_cmd_issue: no command within %0d cycles", n); end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (en_v[0] !== 1'b0) begin errors++; $display("FAIL rstmid_mem_en: got %b expected 0", en_v[0]); end
        checks++; if (done_v[0] !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done_v[0]); end
        rst = 1'b0;
        req_a[0] = 1'b0;
        @(negedge clk);
        cpu_access(0, 1'b0, 16'h0600, 8'h00, "rstmid_fresh_read", cyc);
        checks++; if (get_cmd(0) - c0 != 2) begin errors++; $display("FAIL rstmid_cmds: got %0d expected 2", get_cmd(0) - c0); end
        repeat (20) @(negedge clk);
        cpu_access(0, 1'b0, 16'h0700, 8'h00, "rstpf_read", cyc);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        c0 = get_cmd(0);
        cpu_access(0, 1'b0, 16'h0701, 8'h00, "rstpf_after_reset", cyc);
        checks++; if (get_cmd(0) - c0 != 1) begin errors++; $display("FAIL rstpf_cleared: cmds %0d expected 1", get_cmd(0) - c0); end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_prefetch();
        test_back_to_back();
        test_write_during_pf();
        test_wrap();
        test_no_prefetch();
        test_reset_mid();
        checks++; if (gen[0].consec != 0) begin errors++; $display("FAIL done_consecutive[0]: got %0d expected 0", gen[0].consec); end
        checks++; if (gen[1].consec != 0) begin errors++; $display("FAIL done_consecutive[1]: got %0d expected 0", gen[1].consec); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
